// File: rtl/decode_stage_pipelined.sv
// Decode stage: register file, operand bypass, immediate extension, load-use detection, ID/EX register.
// Optional REG_DEBUG_PORT_EN adds a bypass-free combinational register-file read port.
module decode_stage_pipelined #(
  parameter  int DATA_W    = 32,
  parameter  int REG_COUNT = 32,
  localparam int ADDR_W    = $clog2(REG_COUNT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       instruction,
  input  logic              in_valid,
  input  logic              stall,
  input  logic              flush,
  input  logic              register_write,
  input  logic [ADDR_W-1:0] write_addr,
  input  logic [DATA_W-1:0] write_result,
  input  logic              ex_mem_read,
  input  logic [ADDR_W-1:0] ex_rt_addr,
`ifdef REG_DEBUG_PORT_EN
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
`endif
  output logic [DATA_W-1:0] rs,
  output logic [DATA_W-1:0] rt,
  output logic [ADDR_W-1:0] rs_addr,
  output logic [ADDR_W-1:0] rt_addr,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [4:0]        shamt,
  output logic [DATA_W-1:0] extended_imm,
  output logic              out_valid,
  output logic              hazard_stall
);

  logic [DATA_W-1:0] regs [REG_COUNT];

  logic [5:0]        op;
  logic [ADDR_W-1:0] rs_idx;
  logic [ADDR_W-1:0] rt_idx;
  logic [ADDR_W-1:0] rd_idx;
  logic [4:0]        sh_fld;
  logic [15:0]       imm;
  logic              wr_en;
  logic              zext;
  logic [DATA_W-1:0] rs_val;
  logic [DATA_W-1:0] rt_val;
  logic [DATA_W-1:0] imm_ext;

  assign op     = instruction[31:26];
  assign rs_idx = ADDR_W'(instruction[25:21]);
  assign rt_idx = ADDR_W'(instruction[20:16]);
  assign rd_idx = ADDR_W'(instruction[15:11]);
  assign sh_fld = instruction[10:6];
  assign imm    = instruction[15:0];

  // Address 0 is hard-wired, so writes to it never take effect.
  assign wr_en = register_write && (write_addr != '0);

  // Register file: cleared on reset, written from writeback regardless of pipeline control.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en) begin
      regs[write_addr] <= write_result;
    end
  end

  // Operand read with write-through bypass so a same-cycle writeback is seen.
  always_comb begin
    rs_val = '0;
    rt_val = '0;
    if (rs_idx != '0) begin
      if (wr_en && (write_addr == rs_idx)) begin
        rs_val = write_result;
      end else begin
        rs_val = regs[rs_idx];
      end
    end
    if (rt_idx != '0) begin
      if (wr_en && (write_addr == rt_idx)) begin
        rt_val = write_result;
      end else begin
        rt_val = regs[rt_idx];
      end
    end
  end

  // Logical immediates (andi/ori/xori) zero-extend; everything else sign-extends.
  always_comb begin
    zext = 1'b0;
    unique case (op)
      6'h0C, 6'h0D, 6'h0E: zext = 1'b1;
      default:             zext = 1'b0;
    endcase
    if (zext) begin
      imm_ext = DATA_W'(imm);
    end else begin
      imm_ext = DATA_W'(signed'(imm));
    end
  end

  // Load-use: the load in EX writes a register this instruction needs.
  always_comb begin
    hazard_stall = in_valid && ex_mem_read
                && (ex_rt_addr != '0)
                && ((ex_rt_addr == rs_idx) || (ex_rt_addr == rt_idx));
  end

`ifdef REG_DEBUG_PORT_EN
  // Raw architectural view, deliberately without the writeback bypass.
  always_comb begin
    dbg_data = '0;
    if (dbg_addr != '0) begin
      dbg_data = regs[dbg_addr];
    end
  end
`endif

  // ID/EX register: flush beats stall, stall beats the hazard bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rs           <= '0;
      rt           <= '0;
      rs_addr      <= '0;
      rt_addr      <= '0;
      rd_addr      <= '0;
      shamt        <= '0;
      extended_imm <= '0;
      out_valid    <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (stall) begin
      out_valid <= out_valid;
    end else if (hazard_stall) begin
      out_valid <= 1'b0;
    end else begin
      rs           <= rs_val;
      rt           <= rt_val;
      rs_addr      <= rs_idx;
      rt_addr      <= rt_idx;
      rd_addr      <= rd_idx;
      shamt        <= sh_fld;
      extended_imm <= imm_ext;
      out_valid    <= in_valid;
    end
  end

endmodule
